regfile_wb_ctrl: RTL and testbench
==================================

# regfile_wb_ctrl

Write-port controller and scoreboard for the 32×32 register file. It arbitrates two writeback requesters, the ALU and the load unit, onto the register file's single write port, and registers the winning write. It also keeps a per-register busy scoreboard so decode can stall on operands whose producer has not yet written back. It sits between the execute/memory stages and the register file, and also feeds the decode stall logic.

## Interface
- `NUM_REGS`, default 32: number of architectural registers.
- `AW`, default 5: register address width.
- `DW`, default 32: data width.

Clock and reset: `clk` and `rst_n`, one clock, reset asynchronous and active-low.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `issue_valid` in 1: decode issues an instruction that will write `issue_rd`.
- `issue_rd` in AW: destination register of the issued instruction.
- `issue_ready` out 1: issue accepted; low while `busy[issue_rd]` is set (WAW stall).
- `rs_addr` in AW: decode source operand A.
- `rt_addr` in AW: decode source operand B.
- `rs_busy` out 1: `busy[rs_addr]`, combinational.
- `rt_busy` out 1: `busy[rt_addr]`, combinational.
- `wb0_valid` in 1: ALU writeback request.
- `wb0_addr` in AW: ALU writeback address.
- `wb0_data` in DW: ALU writeback data.
- `wb0_ready` out 1: ALU request granted this cycle.
- `wb1_valid` in 1: load writeback request.
- `wb1_addr` in AW: load writeback address.
- `wb1_data` in DW: load writeback data.
- `wb1_ready` out 1: load request granted this cycle.
- `rf_we` out 1: register file write enable, registered.
- `rf_waddr` out AW: register file write address, registered.
- `rf_wdata` out DW: register file write data, registered.
- `pending` out 6: count of set busy bits, 0..31.

## Operation
- **Scoreboard.**
  - `busy[NUM_REGS-1:0]`; `busy[0]` is hard-wired 0.
  - Issue handshake (`issue_valid & issue_ready`) sets `busy[issue_rd]` at the clock edge.
  - `issue_rd == 0` always gets `issue_ready = 1` and sets nothing.
- **Arbitration.**
  - At most one `wbN_ready` is high per cycle.
  - A grant goes only to an asserted `wbN_valid`.
  - Round-robin two-way, tracked by a 1-bit `last` pointer: the requester not granted last wins a tie; a single requester always wins.
  - `last` updates only on a grant.
- **Commit.**
  - A grant (`wbN_valid & wbN_ready`) clears `busy[wbN_addr]` at the edge.
  - The same edge loads `rf_we = (addr != 0)`, `rf_waddr`, `rf_wdata`.
  - With no grant, `rf_we` is 0 next cycle; `rf_waddr` and `rf_wdata` hold.
- **Simultaneous set and clear of the same register at one edge:** set wins, because a new producer is now pending.
- **Writeback to a non-busy register:** accepted and written; `busy` stays 0; no error.
- **`pending`:** registered population count of `busy`, updated at the same edge as `busy`.

## Timing
- `wbN_ready` and `rs_busy`/`rt_busy` are combinational; all other outputs are registered.
- Write latency: a grant at edge k gives `rf_we = 1` during cycle k+1; the register file captures the write at edge k+1.
- `busy` clears at edge k, so decode sees `rs_busy = 0` in cycle k+1. Decode must read the register file no earlier than cycle k+2, or use the bypass (see Configuration).
- Requesters hold `valid`, `addr` and `data` stable until ready.
- Throughput: one write per cycle sustained.
- A continuously requesting port is granted at least every second cycle.
- Reset values: `rf_we = 0`, `rf_waddr = 0`, `rf_wdata = 0`, `busy = 0`, `pending = 0`, `last = 1` (so `wb0` wins the first tie).
- Reset asserted mid-operation: in-flight writebacks and busy bits are discarded. No write is issued after `rst_n` rises until a new grant occurs.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - Adds outputs `rs_fwd_valid`, `rs_fwd_data`, `rt_fwd_valid`, `rt_fwd_data`.
  - `rsfwd_valid` = `rf_we & (rf_waddr == rs_addr)`, with data `rf_wdata`; the rt pair is equivalent.
  - Decode can then consume the value in cycle k+1.
- Undefined:
  - The ports are absent; the arbitration and scoreboard logic is otherwise identical.
  - Decode waits until k+2.

## Structure
- Package `regfile_pkg`:
  - `REG_AW = 5`, `REG_DW = 32`, `NUM_REGS = 32`.
  - Typedefs `reg_addr_t`, `reg_data_t`.
  - `wb_req_t` struct with fields `valid`, `addr`, `data`.
- One sub-module, `rr_arb2`: two-way round-robin arbiter with inputs `req[1:0]` and `last`, output one-hot `gnt[1:0]`. It is purely combinational; the `last` flop lives in the parent.

## Test plan
- Reset, then `issue_rd = 5` → `busy[5] = 1`, `pending = 1`, `rs_busy = 1` with `rs_addr = 5`; a second issue to `rd = 5` sees `issue_ready = 0`.
- `wb0` writes r5 = 0xDEADBEEF → `wb0_ready = 1`; next cycle `rf_we = 1`, `rf_waddr = 5`, `rf_wdata = 0xDEADBEEF`; `busy[5] = 0`, `pending = 0`.
- `wb0` (r3) and `wb1` (r4) held valid together for 4 cycles from reset → grant order wb0, wb1, wb0, wb1; each is granted once per 2 cycles.
- Issue `rd = 7` and grant a writeback to r7 in the same cycle → `busy[7]` remains 1 and `rf_we` writes r7.
- Writeback to r0 with data 0x1234 → granted, `rf_we = 0`, `busy[0]` stays 0; with `REGFILE_WB_BYPASS_EN`, a commit to r9 with `rs_addr = 9` gives `rs_fwd_valid = 1` and the same data.
- `rst_n` pulsed low while `busy[2]` is set and `wb1` is requesting → all outputs return to reset values immediately; `rf_we = 0` the cycle after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, sizes and helpers for the register file writeback controller
package regfile_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  // Number of set bits in a scoreboard vector; bit 0 is never set, so 0..31 fits in 6 bits.
  function automatic logic [5:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// rtl/regfile_wb_ctrl_rr_arb2.sv - two-way round-robin arbiter, combinational, pointer held by parent
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie the port not granted last time wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - writeback arbiter, registered write port and busy scoreboard; optional REGFILE_WB_BYPASS_EN adds forwarding outputs
module regfile_wb_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic          rs_busy,
  output logic          rt_busy,
  input  logic          wb0_valid,
  input  logic [AW-1:0] wb0_addr,
  input  logic [DW-1:0] wb0_data,
  output logic          wb0_ready,
  input  logic          wb1_valid,
  input  logic [AW-1:0] wb1_addr,
  input  logic [DW-1:0] wb1_data,
  output logic          wb1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [5:0]    pending
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic          rs_fwd_valid,
  output logic [DW-1:0] rs_fwd_data,
  output logic          rt_fwd_valid,
  output logic [DW-1:0] rt_fwd_data
`endif
);

  regfile_pkg::wb_req_t req0;
  regfile_pkg::wb_req_t req1;
  regfile_pkg::wb_req_t sel;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [1:0]          gnt;
  logic                grant;
  logic                last;
  logic                issue_fire;

  assign req0 = '{valid: wb0_valid, addr: wb0_addr, data: wb0_data};
  assign req1 = '{valid: wb1_valid, addr: wb1_addr, data: wb1_data};

  rr_arb2 u_arb (
    .req  ({req1.valid, req0.valid}),
    .last (last),
    .gnt  (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];
  assign grant     = |gnt;
  assign sel       = gnt[1] ? req1 : req0;

  // r0 never has a producer to wait for, so it is always issuable and never marked busy.
  assign issue_ready = (issue_rd == '0) | ~busy[issue_rd];
  assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

  assign rs_busy = busy[rs_addr];
  assign rt_busy = busy[rt_addr];

  // Next scoreboard: commit clears first, then issue sets, so a new producer wins a same-edge collision.
  always_comb begin
    busy_next = busy;
    if (grant) begin
      busy_next[sel.addr] = 1'b0;
    end
    if (issue_fire) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard, its population count and the round-robin pointer (reset favours wb0 on the first tie).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      pending <= '0;
      last    <= 1'b1;
    end else begin
      busy    <= busy_next;
      pending <= regfile_pkg::popcount(busy_next);
      if (grant) begin
        last <= gnt[1];
      end
    end
  end

  // Registered write port; address and data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant & (sel.addr != '0);
      if (grant) begin
        rf_waddr <= sel.addr;
        rf_wdata <= sel.data;
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign rs_fwd_valid = rf_we & (rf_waddr == rs_addr);
  assign rs_fwd_data  = rf_wdata;
  assign rt_fwd_valid = rf_we & (rf_waddr == rt_addr);
  assign rt_fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - directed self-checking bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        wb0_valid;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  pending;
`ifdef REGFILE_WB_BYPASS_EN
  logic        rs_fwd_valid;
  logic [31:0] rs_fwd_data;
  logic        rt_fwd_valid;
  logic [31:0] rt_fwd_data;
`endif

  int n_cmp;
  int n_bad;

  regfile_wb_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .wb0_valid   (wb0_valid),
    .wb0_addr    (wb0_addr),
    .wb0_data    (wb0_data),
    .wb0_ready   (wb0_ready),
    .wb1_valid   (wb1_valid),
    .wb1_addr    (wb1_addr),
    .wb1_data    (wb1_data),
    .wb1_ready   (wb1_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .pending     (pending)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .rs_fwd_valid (rs_fwd_valid),
    .rs_fwd_data  (rs_fwd_data),
    .rt_fwd_valid (rt_fwd_valid),
    .rt_fwd_data  (rt_fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_rd    = '0;
    wb0_valid   = 1'b0;
    wb0_addr    = '0;
    wb0_data    = '0;
    wb1_valid   = 1'b0;
    wb1_addr    = '0;
    wb1_data    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rs_addr = 5'd5;
    rt_addr = 5'd5;
    rst_n   = 1'b0;
    #2;
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_rf: we=%b waddr=%0d wdata=%h, required 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++;
    if (pending !== 6'd0 || rs_busy !== 1'b0 || issue_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_sb: pending=%0d rs_busy=%b issue_ready=%b, required 0/0/1", pending, rs_busy, issue_ready);
    end
    n_cmp++;
    if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: wb0_ready=%b wb1_ready=%b, required 0/0", wb0_ready, wb1_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_issue();
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    rs_addr     = 5'd5;
    #1;
    n_cmp++;
    if (issue_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_first_ready: got %b, required 1", issue_ready);
    end
    tick();
    n_cmp++;
    if (pending !== 6'd1 || rs_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_set: pending=%0d rs_busy=%b, required 1/1", pending, rs_busy);
    end
    n_cmp++;
    if (issue_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL issue_waw_stall: issue_ready=%b, required 0", issue_ready);
    end
    issue_rd = 5'd0;
    #1;
    n_cmp++;
    if (issue_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_r0_ready: issue_ready=%b, required 1", issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    rs_addr     = 5'd0;
    #1;
    n_cmp++;
    if (pending !== 6'd1 || rs_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL issue_r0_noset: pending=%0d busy0=%b, required 1/0", pending, rs_busy);
    end
    rs_addr = 5'd5;
  endtask

  task automatic test_commit();
    wb0_valid = 1'b1;
    wb0_addr  = 5'd5;
    wb0_data  = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL commit_grant: wb0_ready=%b wb1_ready=%b, required 1/0", wb0_ready, wb1_ready);
    end
    tick();
    wb0_valid = 1'b0;
    #1;
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL commit_write: we=%b waddr=%0d wdata=%h, required 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++;
    if (rs_busy !== 1'b0 || pending !== 6'd0) begin
      n_bad++;
      $display("FAIL commit_clear: rs_busy=%b pending=%0d, required 0/0", rs_busy, pending);
    end
    tick();
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL commit_hold: we=%b waddr=%0d wdata=%h, required 0/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g0;
    do_reset();
    exp_g0    = 4'b0101;
    wb0_valid = 1'b1;
    wb0_addr  = 5'd3;
    wb0_data  = 32'h0000_0033;
    wb1_valid = 1'b1;
    wb1_addr  = 5'd4;
    wb1_data  = 32'h0000_0044;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (wb0_ready !== exp_g0[i] || wb1_ready !== ~exp_g0[i]) begin
        n_bad++;
        $display("FAIL rr_grant%0d: wb0_ready=%b wb1_ready=%b, required %b/%b", i, wb0_ready, wb1_ready, exp_g0[i], ~exp_g0[i]);
      end
      tick();
      n_cmp++;
      if (rf_we !== 1'b1 || rf_waddr !== (exp_g0[i] ? 5'd3 : 5'd4)) begin
        n_bad++;
        $display("FAIL rr_write%0d: we=%b waddr=%0d, required 1/%0d", i, rf_we, rf_waddr, exp_g0[i] ? 3 : 4);
      end
    end
    idle_inputs();
    #1;
    n_cmp++;
    if (pending !== 6'd0) begin
      n_bad++;
      $display("FAIL rr_nonbusy_pending: pending=%0d, required 0", pending);
    end
  endtask

  task automatic test_set_clear();
    rt_addr     = 5'd7;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    wb0_valid   = 1'b1;
    wb0_addr    = 5'd7;
    wb0_data    = 32'h0000_0077;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rt_busy !== 1'b1 || pending !== 6'd1) begin
      n_bad++;
      $display("FAIL setclr_busy: rt_busy=%b pending=%0d, required 1/1", rt_busy, pending);
    end
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h0000_0077) begin
      n_bad++;
      $display("FAIL setclr_write: we=%b waddr=%0d wdata=%h, required 1/7/00000077", rf_we, rf_waddr, rf_wdata);
    end
    wb1_valid = 1'b1;
    wb1_addr  = 5'd7;
    wb1_data  = 32'h0000_0777;
    #1;
    n_cmp++;
    if (wb1_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL setclr_wb1_grant: wb1_ready=%b, required 1", wb1_ready);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rt_busy !== 1'b0 || pending !== 6'd0 || rf_wdata !== 32'h0000_0777) begin
      n_bad++;
      $display("FAIL setclr_clear: rt_busy=%b pending=%0d wdata=%h, required 0/0/00000777", rt_busy, pending, rf_wdata);
    end
  endtask

  task automatic test_r0_write();
    rs_addr   = 5'd0;
    wb1_valid = 1'b1;
    wb1_addr  = 5'd0;
    wb1_data  = 32'h0000_1234;
    #1;
    n_cmp++;
    if (wb1_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL r0_grant: wb1_ready=%b, required 1", wb1_ready);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0000_1234 || rs_busy !== 1'b0 || pending !== 6'd0) begin
      n_bad++;
      $display("FAIL r0_write: we=%b waddr=%0d wdata=%h busy0=%b pending=%0d, required 0/0/00001234/0/0",
               rf_we, rf_waddr, rf_wdata, rs_busy, pending);
    end
  endtask

`ifdef REGFILE_WB_BYPASS_EN
  task automatic test_bypass();
    rs_addr   = 5'd9;
    rt_addr   = 5'd9;
    wb0_valid = 1'b1;
    wb0_addr  = 5'd9;
    wb0_data  = 32'h0000_0999;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rs_fwd_valid !== 1'b1 || rs_fwd_data !== 32'h0000_0999 || rt_fwd_valid !== 1'b1 || rt_fwd_data !== 32'h0000_0999) begin
      n_bad++;
      $display("FAIL bypass: rs_v=%b rs_d=%h rt_v=%b rt_d=%h, required 1/00000999/1/00000999",
               rs_fwd_valid, rs_fwd_data, rt_fwd_valid, rt_fwd_data);
    end
    tick();
    n_cmp++;
    if (rs_fwd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bypass_idle: rs_v=%b, required 0", rs_fwd_valid);
    end
  endtask
`endif

  task automatic test_mid_reset();
    rs_addr     = 5'd2;
    issue_valid = 1'b1;
    issue_rd    = 5'd2;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rs_busy !== 1'b1 || pending !== 6'd1) begin
      n_bad++;
      $display("FAIL midrst_pre: rs_busy=%b pending=%0d, required 1/1", rs_busy, pending);
    end
    wb1_valid = 1'b1;
    wb1_addr  = 5'd2;
    wb1_data  = 32'h0000_00AA;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || pending !== 6'd0 || rs_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_async: we=%b waddr=%0d wdata=%h pending=%0d rs_busy=%b, required 0/0/0/0/0",
               rf_we, rf_waddr, rf_wdata, pending, rs_busy);
    end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (rf_we !== 1'b0 || pending !== 6'd0) begin
      n_bad++;
      $display("FAIL midrst_release: we=%b pending=%0d, required 0/0", rf_we, pending);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_issue();
    test_commit();
    test_round_robin();
    test_set_clear();
    test_r0_write();
`ifdef REGFILE_WB_BYPASS_EN
    test_bypass();
`endif
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
